// File: rtl/hyb_pkg.sv
// -----------------------------------------------------------------------------
// hyb_pkg
// Shared definitions for the hybrid radix-2 signed-digit blocks:
//   - hyb_state_e : control states of the accumulator (ACC, CONV, DONE)
//   - ppm_t/ppm_u : bit functions of the plus-plus-minus (PPM) addition cell.
//                   For one bit position, p + y - n == 2*ppm_t - ppm_u.
// -----------------------------------------------------------------------------
package hyb_pkg;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } hyb_state_e;

    // Transfer (weight 2) output of the PPM cell: majority of p, y and ~n.
    function automatic logic ppm_t(input logic p, input logic n, input logic y);
        logic nn;
        nn = ~n;
        return (p & y) | (p & nn) | (y & nn);
    endfunction

    // Negative-weight sum output of the PPM cell.
    function automatic logic ppm_u(input logic p, input logic n, input logic y);
        return p ^ y ^ n;
    endfunction

endpackage

// File: rtl/hyb_accumulator_if.sv
// -----------------------------------------------------------------------------
// hyb_accumulator_if
// Bundles the handshake and data signals of hyb_accumulator.
//   master : producer/consumer side (drives y, in_valid, clr, conv_*, out_ready)
//   slave  : accumulator side (drives ready/valid flags, result, sp, sn)
// -----------------------------------------------------------------------------
interface hyb_accumulator_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             clr;
    logic             conv_start;
    logic             conv_clr;
    logic             conv_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] sn;

    modport master (
        output in_valid, y, clr, conv_start, conv_clr, out_ready,
        input  in_ready, conv_ready, out_valid, result, sp, sn
    );

    modport slave (
        input  in_valid, y, clr, conv_start, conv_clr, out_ready,
        output in_ready, conv_ready, out_valid, result, sp, sn
    );
endinterface

// File: rtl/hyb_ppm_stage.sv
// -----------------------------------------------------------------------------
// hyb_ppm_stage
// Purely combinational WIDTH-bit row of PPM cells: adds a two's-complement
// operand y into a redundant (sp, sn) pair without carry propagation.
// Ports:
//   sp_i, sn_i : current positive / negative vectors
//   y_i        : addend
//   sp_o, sn_o : next positive / negative vectors, (sp_o - sn_o) == sp_i - sn_i + y_i
//                modulo 2^WIDTH
// -----------------------------------------------------------------------------
module hyb_ppm_stage
    import hyb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sp_i,
    input  logic [WIDTH-1:0] sn_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] sp_o,
    output logic [WIDTH-1:0] sn_o
);

    logic [WIDTH-1:0] t_s;

    // Per-bit PPM cells; the transfer vector moves one position up, and the
    // top transfer bit falls off (modulo 2^WIDTH wrap).
    always_comb begin
        t_s  = '0;
        sn_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_s[i]  = ppm_t(sp_i[i], sn_i[i], y_i[i]);
            sn_o[i] = ppm_u(sp_i[i], sn_i[i], y_i[i]);
        end
        sp_o = t_s << 1;
    end

endmodule

// File: rtl/hyb_accumulator.sv
// -----------------------------------------------------------------------------
// hyb_accumulator
// Carry-free accumulator: each accepted y is folded into the redundant pair
// (sp, sn) in one cycle. A conversion request snapshots the pair and resolves
// sp - sn into two's complement CHUNK bits per cycle.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   acc_if    : slave side of hyb_accumulator_if
//               in_valid/in_ready/y      : addend stream
//               clr                      : clear (or load y) in ACC
//               conv_start/conv_clr      : conversion request, optional clear
//               conv_ready               : request can be accepted
//               out_valid/out_ready      : converted result handshake
//               result, sp, sn           : converted value and raw pair
// -----------------------------------------------------------------------------
module hyb_accumulator
    import hyb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    hyb_accumulator_if.slave  acc_if
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("hyb_accumulator: WIDTH must be a multiple of CHUNK");
    end

    hyb_state_e       state_q;
    logic [CW-1:0]    chunk_q;
    logic             borrow_q;
    logic [WIDTH-1:0] p_snap_q;
    logic [WIDTH-1:0] n_snap_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] sp_q;
    logic [WIDTH-1:0] sn_q;
    logic             in_ready_q;
    logic             conv_ready_q;
    logic             out_valid_q;

    logic             in_acc_s;
    logic             acc_fire_s;
    logic             conv_fire_s;
    logic [WIDTH-1:0] sp_ppm_s;
    logic [WIDTH-1:0] sn_ppm_s;
    logic [WIDTH-1:0] sp_sum_s;
    logic [WIDTH-1:0] sn_sum_s;
    logic [WIDTH-1:0] sp_nxt_s;
    logic [WIDTH-1:0] sn_nxt_s;
    logic [WIDTH-1:0] sp_d;
    logic [WIDTH-1:0] sn_d;
    logic [WIDTH-1:0] p_snap_d;
    logic [WIDTH-1:0] n_snap_d;
    logic [IW-1:0]    base_s;
    logic [CHUNK-1:0] p_chunk_s;
    logic [CHUNK-1:0] n_chunk_s;
    logic [CHUNK:0]   diff_s;
    logic             last_chunk_s;

    assign in_acc_s    = (state_q == ST_ACC);
    assign acc_fire_s  = in_acc_s & acc_if.in_valid;
    assign conv_fire_s = in_acc_s & acc_if.conv_start;

    hyb_ppm_stage #(.WIDTH(WIDTH)) u_ppm (
        .sp_i (sp_q),
        .sn_i (sn_q),
        .y_i  (acc_if.y),
        .sp_o (sp_ppm_s),
        .sn_o (sn_ppm_s)
    );

    // Next accumulator value and conversion snapshot. A conv_clr request
    // overrides clr, so the snapshot then carries the plain running sum.
    always_comb begin
        if (acc_fire_s) begin
            sp_sum_s = sp_ppm_s;
            sn_sum_s = sn_ppm_s;
        end else begin
            sp_sum_s = sp_q;
            sn_sum_s = sn_q;
        end

        if (in_acc_s && acc_if.clr) begin
            sp_nxt_s = acc_fire_s ? acc_if.y : {WIDTH{1'b0}};
            sn_nxt_s = {WIDTH{1'b0}};
        end else begin
            sp_nxt_s = sp_sum_s;
            sn_nxt_s = sn_sum_s;
        end

        if (acc_if.conv_clr) begin
            p_snap_d = sp_sum_s;
            n_snap_d = sn_sum_s;
        end else begin
            p_snap_d = sp_nxt_s;
            n_snap_d = sn_nxt_s;
        end

        if (conv_fire_s && acc_if.conv_clr) begin
            sp_d = {WIDTH{1'b0}};
            sn_d = {WIDTH{1'b0}};
        end else begin
            sp_d = sp_nxt_s;
            sn_d = sn_nxt_s;
        end
    end

    // Chunk subtractor: one CHUNK-wide slice of p - n - borrow per cycle.
    always_comb begin
        base_s       = IW'(chunk_q) * IW'(CHUNK);
        p_chunk_s    = p_snap_q[base_s +: CHUNK];
        n_chunk_s    = n_snap_q[base_s +: CHUNK];
        diff_s       = {1'b0, p_chunk_s} - {1'b0, n_chunk_s} - {{CHUNK{1'b0}}, borrow_q};
        last_chunk_s = (chunk_q == CW'(NCH - 1));
    end

    // Redundant accumulator pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= {WIDTH{1'b0}};
            sn_q <= {WIDTH{1'b0}};
        end else begin
            sp_q <= sp_d;
            sn_q <= sn_d;
        end
    end

    // Control FSM with snapshot, chunk counter, borrow, result and the
    // registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ACC;
            chunk_q      <= {CW{1'b0}};
            borrow_q     <= 1'b0;
            p_snap_q     <= {WIDTH{1'b0}};
            n_snap_q     <= {WIDTH{1'b0}};
            result_q     <= {WIDTH{1'b0}};
            in_ready_q   <= 1'b1;
            conv_ready_q <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (conv_fire_s) begin
                        state_q      <= ST_CONV;
                        p_snap_q     <= p_snap_d;
                        n_snap_q     <= n_snap_d;
                        borrow_q     <= 1'b0;
                        chunk_q      <= {CW{1'b0}};
                        in_ready_q   <= 1'b0;
                        conv_ready_q <= 1'b0;
                    end
                end
                ST_CONV: begin
                    result_q[base_s +: CHUNK] <= diff_s[CHUNK-1:0];
                    borrow_q                  <= diff_s[CHUNK];
                    if (last_chunk_s) begin
                        state_q     <= ST_DONE;
                        chunk_q     <= {CW{1'b0}};
                        out_valid_q <= 1'b1;
                    end else begin
                        chunk_q <= chunk_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (acc_if.out_ready) begin
                        state_q      <= ST_ACC;
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                        conv_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_ACC;
                    out_valid_q  <= 1'b0;
                    in_ready_q   <= 1'b1;
                    conv_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign acc_if.in_ready   = in_ready_q;
    assign acc_if.conv_ready = conv_ready_q;
    assign acc_if.out_valid  = out_valid_q;
    assign acc_if.result     = result_q;
    assign acc_if.sp         = sp_q;
    assign acc_if.sn         = sn_q;

endmodule

// File: tb/tb_hyb_accumulator.sv
// -----------------------------------------------------------------------------
// tb_hyb_accumulator
// Drives three accumulators (CHUNK = 1, 4, 16) with the same stimulus. Each
// conversion request pushes the expected result into a per-DUT queue; a
// monitor per DUT pops and compares on every out_valid/out_ready handshake.
// -----------------------------------------------------------------------------
module tb_hyb_accumulator;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid_s = 1'b0;
    logic [W-1:0] y_s = '0;
    logic         clr_s = 1'b0;
    logic         conv_start_s = 1'b0;
    logic         conv_clr_s = 1'b0;
    logic         out_ready_s = 1'b1;

    always #5 clk = ~clk;

    hyb_accumulator_if #(.WIDTH(W)) b1 ();
    hyb_accumulator_if #(.WIDTH(W)) b4 ();
    hyb_accumulator_if #(.WIDTH(W)) b16 ();

    assign b1.in_valid   = in_valid_s;   assign b4.in_valid   = in_valid_s;   assign b16.in_valid   = in_valid_s;
    assign b1.y          = y_s;          assign b4.y          = y_s;          assign b16.y          = y_s;
    assign b1.clr        = clr_s;        assign b4.clr        = clr_s;        assign b16.clr        = clr_s;
    assign b1.conv_start = conv_start_s; assign b4.conv_start = conv_start_s; assign b16.conv_start = conv_start_s;
    assign b1.conv_clr   = conv_clr_s;   assign b4.conv_clr   = conv_clr_s;   assign b16.conv_clr   = conv_clr_s;
    assign b1.out_ready  = out_ready_s;  assign b4.out_ready  = out_ready_s;  assign b16.out_ready  = out_ready_s;

    hyb_accumulator #(.WIDTH(W), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .acc_if(b1));
    hyb_accumulator #(.WIDTH(W), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .acc_if(b4));
    hyb_accumulator #(.WIDTH(W), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .acc_if(b16));

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] q1[$];
    logic [W-1:0] q4[$];
    logic [W-1:0] q16[$];
    logic [W-1:0] model_sum = '0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endfunction

    function automatic void chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void no_expect(input string name, input logic [W-1:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: result 0x%04h presented with nothing expected", name, act);
    endfunction

    // Scoreboard monitors, one per DUT.
    always @(negedge clk) begin
        if (!rst && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) no_expect("dut1_result", b1.result);
            else chk("dut1_result", b1.result, q1.pop_front());
        end
    end
    always @(negedge clk) begin
        if (!rst && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) no_expect("dut4_result", b4.result);
            else chk("dut4_result", b4.result, q4.pop_front());
        end
    end
    always @(negedge clk) begin
        if (!rst && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) no_expect("dut16_result", b16.result);
            else chk("dut16_result", b16.result, q16.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One ACC-state cycle; updates the reference sum and queues expected results.
    task automatic cycle(input logic v, input logic [W-1:0] y, input logic c,
                         input logic cs, input logic cc);
        logic [W-1:0] add;
        logic [W-1:0] nxt;
        logic [W-1:0] snap;
        add = v ? y : '0;
        nxt = c ? add : model_sum + add;
        in_valid_s = v; y_s = y; clr_s = c; conv_start_s = cs; conv_clr_s = cc;
        if (cs) begin
            snap = cc ? (model_sum + add) : nxt;
            q1.push_back(snap); q4.push_back(snap); q16.push_back(snap);
            model_sum = cc ? '0 : nxt;
        end else begin
            model_sum = nxt;
        end
        step();
        in_valid_s = 1'b0; clr_s = 1'b0; conv_start_s = 1'b0; conv_clr_s = 1'b0;
    endtask

    task automatic wait_all_acc(input bit rnd_ready);
        for (int i = 0; i < 200; i++) begin
            if (b1.conv_ready && b4.conv_ready && b16.conv_ready) break;
            if (rnd_ready) out_ready_s = 1'($urandom_range(0, 1));
            step();
        end
        out_ready_s = 1'b1;
        if (!(b1.conv_ready && b4.conv_ready && b16.conv_ready)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_acc: timeout, conv_ready=%b%b%b expected 111",
                     b1.conv_ready, b4.conv_ready, b16.conv_ready);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        logic got_valid;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_sp", b4.sp, 16'h0000);
        chk("rst_sn", b4.sn, 16'h0000);
        chk("rst_result", b4.result, 16'h0000);
        chkb("rst_out_valid", b4.out_valid, 1'b0);
        chkb("rst_in_ready", b4.in_ready, 1'b1);
        chkb("rst_conv_ready", b4.conv_ready, 1'b1);

        // Basic sum with latency check (CHUNK=4: out_valid after E4)
        cycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("sum_invariant", b4.sp - b4.sn, 16'h0007);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(); step(); step();
        chkb("lat_e3_out_valid", b4.out_valid, 1'b0);
        step();
        chkb("lat_e4_out_valid", b4.out_valid, 1'b1);
        wait_all_acc(1'b0);

        // Wrap-around
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("clr_sp", b4.sp, 16'h0000);
        cycle(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        wait_all_acc(1'b0);
        cycle(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        wait_all_acc(1'b0);

        // Simultaneous input and conversion with conv_clr, then empty conversion
        cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h000A, 1'b0, 1'b1, 1'b1);
        chk("conv_clr_sp", b4.sp, 16'h0000);
        wait_all_acc(1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        wait_all_acc(1'b0);

        // clr together with conv_clr acts as conv_clr: snapshot 3+4
        cycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0004, 1'b1, 1'b1, 1'b1);
        wait_all_acc(1'b0);

        // Backpressure in DONE
        cycle(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        out_ready_s = 1'b0;
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        got_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b4.out_valid) begin got_valid = 1'b1; break; end
            step();
        end
        chkb("bp_out_valid_seen", got_valid, 1'b1);
        in_valid_s = 1'b1;
        y_s = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_result_stable", b4.result, 16'h0033);
            chkb("bp_in_ready", b4.in_ready, 1'b0);
            chkb("bp_out_valid", b4.out_valid, 1'b1);
            chk("bp_sum_unchanged", b4.sp - b4.sn, 16'h0033);
        end
        in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        step();
        chkb("bp_release_acc", b4.conv_ready, 1'b1);
        chkb("bp_release_out_valid", b4.out_valid, 1'b0);
        chk("bp_result_held", b4.result, 16'h0033);
        wait_all_acc(1'b0);

        // Reset in the middle of a conversion
        cycle(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(); step();
        rst = 1'b1;
        #1;
        chkb("mid_rst_out_valid", b4.out_valid, 1'b0);
        chk("mid_rst_sp", b4.sp, 16'h0000);
        chk("mid_rst_sn", b4.sn, 16'h0000);
        q1.delete(); q4.delete(); q16.delete();
        model_sum = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b4.out_valid || b1.out_valid) seen_valid = 1'b1;
        end
        chkb("mid_rst_no_valid", seen_valid, 1'b0);
        chkb("mid_rst_in_ready", b4.in_ready, 1'b1);
        chk("mid_rst_result", b4.result, 16'h0000);

        // clr with input loads y
        cycle(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        chk("clr_load_sp", b4.sp, 16'h1234);
        chk("clr_load_sn", b4.sn, 16'h0000);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        wait_all_acc(1'b0);

        // Random regression against the modulo-2^16 reference sum
        for (int n = 0; n < 1000; n++) begin
            logic v, c, cs, cc;
            logic [W-1:0] yv;
            v  = ($urandom_range(0, 3) != 0);
            yv = W'($urandom);
            c  = ($urandom_range(0, 15) == 0);
            cs = ($urandom_range(0, 11) == 0);
            cc = 1'($urandom_range(0, 1));
            cycle(v, yv, c, cs, cc);
            if (cs) wait_all_acc(1'b1);
            chk("rnd_inv_dut4", b4.sp - b4.sn, model_sum);
            chk("rnd_inv_dut1", b1.sp - b1.sn, model_sum);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        wait_all_acc(1'b0);
        step();

        chk("drain_q1", W'(q1.size()), 16'h0000);
        chk("drain_q4", W'(q4.size()), 16'h0000);
        chk("drain_q16", W'(q16.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
